// File: rtl/wb_ctrl_pkg.sv
// Purpose: shared opcode/funct constants and the writeback control record for the WB control pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: opcode/funct constants, wb_sel_e encoding, wb_ctl_t control fields.
// A full stage record is {wb_ctl_t ctl, dst[RA_W-1:0]} = {reg_wr, mem_rd, sel[1:0], dst}.
package wb_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  // Link register written by JAL.
  localparam int unsigned LINK_REG = 31;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  // Control half of a stage record; the destination field is appended by
  // users because its width is a module parameter.
  typedef struct packed {
    logic    reg_wr;
    logic    mem_rd;
    wb_sel_e sel;
  } wb_ctl_t;

endpackage

// File: rtl/wb_ctrl_decode.sv
// Purpose: combinational decode of one instruction into a writeback control record.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the input every cycle.
// Ports: inst_i/valid_i instruction in; ctl_o {reg_wr,mem_rd,sel}, dst_o destination register.
// Option: WB_LINK_EN enables JAL/JALR link writes (sel LINK); otherwise JAL is a NOP.
import wb_ctrl_pkg::*;

module wb_ctrl_decode #(
  parameter int INST_W = 32,
  parameter int RA_W   = 5
) (
  input  logic [INST_W-1:0] inst_i,
  input  logic              valid_i,
  output wb_ctl_t           ctl_o,
  output logic [RA_W-1:0]   dst_o
);

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [RA_W-1:0] rd;
  logic [RA_W-1:0] rt;
  wb_ctl_t         ctl;
  logic [RA_W-1:0] dst;

  assign opcode = inst_i[31:26];
  assign funct  = inst_i[5:0];
  assign rd     = inst_i[11 +: RA_W];
  assign rt     = inst_i[16 +: RA_W];

  // rs and shamt do not influence writeback control.
  logic unused_fields;
  assign unused_fields = ^{inst_i[25:21], inst_i[10:6]};

  always_comb begin
    ctl = '{reg_wr: 1'b0, mem_rd: 1'b0, sel: WB_SEL_ALU};
    dst = '0;
    if (valid_i) begin
      unique case (opcode)
        OP_RTYPE: begin
          if (funct != FN_JR) begin
            ctl.reg_wr = 1'b1;
            dst        = rd;
`ifdef WB_LINK_EN
            if (funct == FN_JALR) ctl.sel = WB_SEL_LINK;
`endif
          end
        end
        OP_LW: begin
          ctl = '{reg_wr: 1'b1, mem_rd: 1'b1, sel: WB_SEL_MEM};
          dst = rt;
        end
        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: begin
          ctl.reg_wr = 1'b1;
          dst        = rt;
        end
`ifdef WB_LINK_EN
        OP_JAL: begin
          ctl = '{reg_wr: 1'b1, mem_rd: 1'b0, sel: WB_SEL_LINK};
          dst = RA_W'(LINK_REG);
        end
`endif
        default: ;
      endcase
    end
    // A $0 destination is squashed to a full NOP: nothing is written, and a
    // load into $0 can never be a load-use hazard, so no stale fields travel.
    if (dst == '0) begin
      ctl = '{reg_wr: 1'b0, mem_rd: 1'b0, sel: WB_SEL_ALU};
    end
  end

  assign ctl_o = ctl;
  assign dst_o = dst;

endmodule

// File: rtl/wb_ctrl_pipe.sv
// Purpose: decode writeback controls in ID and carry them through DEPTH pipeline stages.
// Latency: DEPTH clk edges from decode to wb_* outputs (absent hold).
// Backpressure: hold freezes all stages; bubble/flush inject a NOP into stage 0 while later stages advance.
// Ports: clk, rst_n (async active-low); id_inst/id_valid decode input; hold/bubble/flush control;
//        stg_reg_wr/stg_dst/stg_mem_rd per-stage views; wb_reg_wr/wb_dst/wb_sel at the last stage.
// Option: WB_LINK_EN (see wb_ctrl_decode) enables link writes for JAL/JALR.
import wb_ctrl_pkg::*;

module wb_ctrl_pipe #(
  parameter int DEPTH  = 3,   // legal 2..6; stage 0 is ID/EX, stage DEPTH-1 is WB
  parameter int INST_W = 32,
  parameter int RA_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INST_W-1:0]      id_inst,
  input  logic                   id_valid,
  input  logic                   hold,
  input  logic                   bubble,
  input  logic                   flush,
  output logic [DEPTH-1:0]       stg_reg_wr,
  output logic [DEPTH*RA_W-1:0]  stg_dst,
  output logic [DEPTH-1:0]       stg_mem_rd,
  output logic                   wb_reg_wr,
  output logic [RA_W-1:0]        wb_dst,
  output logic [1:0]             wb_sel
);

  typedef struct packed {
    wb_ctl_t         ctl;
    logic [RA_W-1:0] dst;
  } stage_t;

  stage_t dec_rec;
  stage_t stage_q [DEPTH];
  stage_t stage_d [DEPTH];

  wb_ctrl_decode #(
    .INST_W (INST_W),
    .RA_W   (RA_W)
  ) u_decode (
    .inst_i  (id_inst),
    .valid_i (id_valid),
    .ctl_o   (dec_rec.ctl),
    .dst_o   (dec_rec.dst)
  );

  // hold has priority: a flush arriving during hold is dropped, the
  // requester keeps it asserted until the pipe moves.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (!hold) begin
      stage_d[0] = (flush || bubble) ? '0 : dec_rec;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // All outputs come straight from stage registers.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stg_out
    assign stg_reg_wr[g]            = stage_q[g].ctl.reg_wr;
    assign stg_mem_rd[g]            = stage_q[g].ctl.mem_rd;
    assign stg_dst[g*RA_W +: RA_W]  = stage_q[g].dst;
  end

  assign wb_reg_wr = stage_q[DEPTH-1].ctl.reg_wr;
  assign wb_dst    = stage_q[DEPTH-1].dst;
  assign wb_sel    = stage_q[DEPTH-1].ctl.sel;

endmodule
